// File: rtl/sd_spi_card_responder.sv
// sd_spi_card_responder
// ---------------------
// Device side of an SD card in SPI mode. It is the bench partner and loopback
// target for the SD host initializer/reader. It takes 48-bit command frames on
// MOSI and answers on MISO. Supported commands are CMD0, CMD8, CMD55, ACMD41,
// CMD58 and CMD17. The CMD17 block payload is read from an external byte
// source.
//
// Optional feature:
//   SD_RESPONDER_CRC16_EN  defined  : the data CRC is CRC-16-CCITT
//                                     (poly 0x1021, init 0), computed serially
//                                     over the payload bits.
//                          undefined: the data CRC is sent as 0xFFFF.
//
// Ports:
//   SCLK       in   SPI clock. All logic runs on the rising edge.
//   reset      in   Asynchronous, active-high.
//   CS         in   Chip select, active-low. High aborts any frame.
//   MOSI       in   Command bits, MSB first.
//   MISO       out  Response/data bits, MSB first (registered).
//   blk_addr   out  CMD17 argument, latched at decode.
//   byte_idx   out  Index of the payload byte being fetched.
//   byte_data  in   Payload byte for {blk_addr, byte_idx}. Combinational
//                   source, sampled when the byte is loaded.
//   in_idle    out  Card idle flag (R1 bit 0).
//   cmd_valid  out  One-cycle strobe when a frame completes.
//   cmd_index  out  Index of the last completed frame.
//   dbg_state  out  Current FSM state encoding, for observation.
//
// Handshake: cmd_valid is a strobe with no ready. It is high for exactly one
// SCLK cycle, the cycle after the frame end bit is sampled. cmd_index is
// valid from that cycle onward and holds until the next completed frame.

module sd_spi_card_responder #(
    parameter int ACMD41_BUSY_COUNT = 2,
    parameter int NCR_BYTES         = 1,
    parameter int DATA_WAIT_BYTES   = 2,
    parameter int BLOCK_BYTES       = 512
) (
    input  logic        SCLK,
    input  logic        reset,
    input  logic        CS,
    input  logic        MOSI,
    output logic        MISO,
    output logic [31:0] blk_addr,
    output logic [8:0]  byte_idx,
    input  logic [7:0]  byte_data,
    output logic        in_idle,
    output logic        cmd_valid,
    output logic [5:0]  cmd_index,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_WAIT  = 3'd0,
        S_CMD   = 3'd1,
        S_NCR   = 3'd2,
        S_RESP  = 3'd3,
        S_DWAIT = 3'd4,
        S_TOKEN = 3'd5,
        S_DATA  = 3'd6,
        S_CRC   = 3'd7
    } state_t;

    // Last value of the per-state cycle counter before leaving each state.
    localparam logic [15:0] CMD_LAST   = 16'd46;
    localparam logic [15:0] NCR_LAST   = 16'(NCR_BYTES * 8 - 1);
    localparam logic [15:0] DWAIT_LAST = 16'(DATA_WAIT_BYTES * 8 - 1);
    localparam logic [15:0] DATA_LAST  = 16'(BLOCK_BYTES * 8 - 1);
    localparam logic [8:0]  IDX_LAST   = 9'(BLOCK_BYTES - 1);
    localparam logic [3:0]  BUSY_INIT  = 4'(ACMD41_BUSY_COUNT);

    state_t      state, state_next;
    logic [15:0] cnt;          // cycles spent in the current state
    logic [37:0] cmd_sr;       // {index, argument} of the incoming frame
    logic [39:0] tx_sr, tx_d;  // outgoing bits, MSB is the next MISO bit
    logic        miso_d;
    logic        app_cmd;
    logic [3:0]  busy_cnt;
    logic        resp_long;    // R7/R3: 32 bits follow R1
    logic        data_go;      // CMD17 accepted, block follows R1
    logic        decode;

    // Decoder results, applied on the decode edge.
    logic [5:0]  dec_idx;
    logic [31:0] dec_arg;
    logic [7:0]  dec_r1;
    logic [31:0] dec_payload;
    logic        dec_long;
    logic        dec_data_go;
    logic        dec_idle;
    logic [3:0]  dec_busy;
    logic        dec_app;
    logic        dec_set_addr;

    logic [15:0] crc_word;

    assign dbg_state = state;
    assign dec_idx   = cmd_sr[37:32];
    assign dec_arg   = cmd_sr[31:0];
    assign decode    = (state == S_CMD) && (state_next == S_NCR);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge SCLK or posedge reset) begin
        if (reset) begin
            state <= S_WAIT;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        if (CS) begin
            state_next = S_WAIT;
        end else begin
            case (state)
                S_WAIT:  if (!MOSI) state_next = S_CMD;
                S_CMD:   if (cnt == CMD_LAST) state_next = S_NCR;
                S_NCR:   if (cnt == NCR_LAST) state_next = S_RESP;
                S_RESP: begin
                    if (cnt == (resp_long ? 16'd39 : 16'd7)) begin
                        if (!data_go)                  state_next = S_WAIT;
                        else if (DATA_WAIT_BYTES == 0) state_next = S_TOKEN;
                        else                           state_next = S_DWAIT;
                    end
                end
                S_DWAIT: if (cnt == DWAIT_LAST) state_next = S_TOKEN;
                S_TOKEN: if (cnt == 16'd7) state_next = S_DATA;
                S_DATA:  if (cnt == DATA_LAST) state_next = S_CRC;
                S_CRC:   if (cnt == 16'd15) state_next = S_WAIT;
                default: state_next = S_WAIT;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Command decoder. It uses the flag values from before the decode edge.
    // ------------------------------------------------------------------
    always_comb begin
        dec_r1       = {5'b0, 1'b1, 1'b0, in_idle};  // illegal command
        dec_payload  = 32'hFFFF_FFFF;
        dec_long     = 1'b0;
        dec_data_go  = 1'b0;
        dec_idle     = in_idle;
        dec_busy     = busy_cnt;
        dec_app      = 1'b0;
        dec_set_addr = 1'b0;
        case (dec_idx)
            6'd0: begin
                dec_r1   = 8'h01;
                dec_idle = 1'b1;
                dec_busy = BUSY_INIT;
            end
            6'd8: begin
                dec_r1      = {7'b0, in_idle};
                dec_long    = 1'b1;
                dec_payload = {20'h00000, dec_arg[11:0]};
            end
            6'd55: begin
                dec_r1  = {7'b0, in_idle};
                dec_app = 1'b1;
            end
            6'd41: begin
                if (app_cmd) begin
                    if (busy_cnt != 4'd0) begin
                        dec_busy = busy_cnt - 4'd1;
                        dec_r1   = 8'h01;
                    end else begin
                        dec_idle = 1'b0;
                        dec_r1   = 8'h00;
                    end
                end
            end
            6'd58: begin
                dec_r1      = {7'b0, in_idle};
                dec_long    = 1'b1;
                dec_payload = {~in_idle, 1'b1, 6'b0, 24'hFF8000};
            end
            6'd17: begin
                if (in_idle) begin
                    dec_r1 = 8'h05;
                end else begin
                    dec_r1       = 8'h00;
                    dec_set_addr = 1'b1;
                    dec_data_go  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic. MISO is registered, so the bit for the next cycle is
    // chosen from the state being entered. The first bit of each phase
    // then appears in that phase's first cycle.
    // ------------------------------------------------------------------
    always_comb begin
        logic        load;
        logic [39:0] word;
        miso_d = 1'b1;
        tx_d   = tx_sr;
        load   = 1'b0;
        word   = tx_sr;
        case (state_next)
            S_NCR: begin
                // The response is parked in the shifter while the NCR ones go out.
                if (state == S_CMD) begin
                    tx_d = {dec_r1, dec_long ? dec_payload : 32'hFFFF_FFFF};
                end
            end
            S_RESP: begin
                miso_d = tx_sr[39];
                tx_d   = {tx_sr[38:0], 1'b1};
            end
            S_TOKEN, S_DATA, S_CRC: begin
                if (state_next != state) begin
                    load = 1'b1;
                end else if (state_next == S_DATA && cnt[2:0] == 3'd7) begin
                    load = 1'b1;
                end
                if (load) begin
                    case (state_next)
                        S_TOKEN: word = {8'hFE, 32'hFFFF_FFFF};
                        S_DATA:  word = {byte_data, 32'hFFFF_FFFF};
                        default: word = {crc_word, 24'hFF_FFFF};
                    endcase
                end
                miso_d = word[39];
                tx_d   = {word[38:0], 1'b1};
            end
            default: ;
        endcase
    end

`ifdef SD_RESPONDER_CRC16_EN
    // The CRC advances on every payload bit that is on MISO. The value
    // loaded into S_CRC already includes the final payload bit.
    logic [15:0] crc, crc_next;

    always_comb begin
        crc_next = {crc[14:0], 1'b0} ^ ((crc[15] ^ MISO) ? 16'h1021 : 16'h0000);
        crc_word = crc_next;
    end

    always_ff @(posedge SCLK or posedge reset) begin
        if (reset) begin
            crc <= 16'h0000;
        end else begin
            crc <= (state == S_DATA) ? crc_next : 16'h0000;
        end
    end
`else
    assign crc_word = 16'hFFFF;
`endif

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge SCLK or posedge reset) begin
        if (reset) begin
            MISO      <= 1'b1;
            tx_sr     <= '1;
            cnt       <= '0;
            cmd_sr    <= '0;
            in_idle   <= 1'b1;
            busy_cnt  <= BUSY_INIT;
            app_cmd   <= 1'b0;
            cmd_valid <= 1'b0;
            cmd_index <= 6'd0;
            blk_addr  <= 32'd0;
            byte_idx  <= 9'd0;
            resp_long <= 1'b0;
            data_go   <= 1'b0;
        end else begin
            MISO      <= miso_d;
            tx_sr     <= tx_d;
            cmd_valid <= decode;

            if (state_next != state || state_next == S_WAIT) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 16'd1;
            end

            // Only index and argument are kept. The transmission bit, CRC7
            // and end bit are not stored.
            if (state == S_CMD && cnt >= 16'd1 && cnt <= 16'd38) begin
                cmd_sr <= {cmd_sr[36:0], MOSI};
            end

            if (decode) begin
                cmd_index <= dec_idx;
                in_idle   <= dec_idle;
                busy_cnt  <= dec_busy;
                app_cmd   <= dec_app;
                resp_long <= dec_long;
                data_go   <= dec_data_go;
                if (dec_set_addr) begin
                    blk_addr <= dec_arg;
                end
            end

            // byte_idx moves to the next byte during the last bit of the
            // current byte. It is therefore stable for one full cycle before
            // the load edge.
            if (state_next == S_WAIT) begin
                byte_idx <= 9'd0;
            end else if (state == S_DATA && cnt[2:0] == 3'd6) begin
                byte_idx <= (byte_idx == IDX_LAST) ? 9'd0 : byte_idx + 9'd1;
            end
        end
    end

endmodule
